// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
// Upstream feeder of the IO logical-tile configuration chain. Parallel
// configuration words arrive over a valid/ready handshake and are
// serialized MSB-first onto ccff_head. prog_clk_en gates the chain's
// prog_clk, so the chain advances only on the cycles where this loader
// presents a bit. After the last word, ccff_tail is compared with the
// first bit shifted in. IO isolation is held until a load ends cleanly.
//
// Ports:
//   prog_clk      configuration clock, rising edge
//   prog_reset    asynchronous active-high reset
//   start         one-cycle pulse, begins a load from IDLE or DONE
//   cfg_data      configuration word, MSB shifted first
//   cfg_valid     cfg_data/cfg_last valid
//   cfg_last      marks final word of the sequence
//   cfg_ready     word accepted when cfg_valid & cfg_ready (registered)
//   ccff_head     serial data into chain (registered)
//   prog_clk_en   chain shifts at edges where high (registered)
//   ccff_tail     last chain flop output
//   isol_n        IO isolation, low = isolated (registered)
//   busy          high in WAIT_WORD, SHIFT, CHECK
//   done          high in DONE
//   tail_error    sticky loopback mismatch
//   length_error  sticky shifted-bit count mismatch
module ccff_chain_loader #(
  parameter int WORD_WIDTH = 8,
  parameter int CHAIN_LEN  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] cfg_data,
  input  logic                  cfg_valid,
  input  logic                  cfg_last,
  output logic                  cfg_ready,
  output logic                  ccff_head,
  output logic                  prog_clk_en,
  input  logic                  ccff_tail,
  output logic                  isol_n,
  output logic                  busy,
  output logic                  done,
  output logic                  tail_error,
  output logic                  length_error
);

  localparam int BIDX_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [CNT_WIDTH-1:0] CHAIN_LEN_C = CNT_WIDTH'(CHAIN_LEN);
  localparam logic [BIDX_W-1:0]    LAST_BIT    = BIDX_W'(WORD_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_WORD = 3'd1,
    SHIFT     = 3'd2,
    CHECK     = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [WORD_WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [BIDX_W-1:0]       bidx_q, bidx_d;
  logic                    last_q, last_d;
  logic                    first_bit_q, first_bit_d;
  logic                    tail_err_q, tail_err_d;
  logic                    len_err_q, len_err_d;
  logic                    ready_q, ready_d;
  logic                    head_q, head_d;
  logic                    en_q, en_d;
  logic                    isol_q, isol_d;

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      bidx_q      <= '0;
      last_q      <= 1'b0;
      first_bit_q <= 1'b0;
      tail_err_q  <= 1'b0;
      len_err_q   <= 1'b0;
      ready_q     <= 1'b0;
      head_q      <= 1'b0;
      en_q        <= 1'b0;
      isol_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      bidx_q      <= bidx_d;
      last_q      <= last_d;
      first_bit_q <= first_bit_d;
      tail_err_q  <= tail_err_d;
      len_err_q   <= len_err_d;
      ready_q     <= ready_d;
      head_q      <= head_d;
      en_q        <= en_d;
      isol_q      <= isol_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    bidx_d      = bidx_q;
    last_d      = last_q;
    first_bit_d = first_bit_q;
    tail_err_d  = tail_err_q;
    len_err_d   = len_err_q;
    ready_d     = ready_q;
    head_d      = head_q;
    en_d        = en_q;
    isol_d      = isol_q;
    // The enable is only ever raised below CHAIN_LEN, so this never wraps.
    cnt_inc     = en_q ? cnt_q + 1'b1 : cnt_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = WAIT_WORD;
          cnt_d      = '0;
          tail_err_d = 1'b0;
          len_err_d  = 1'b0;
          isol_d     = 1'b0;
          ready_d    = 1'b1;
        end
      end
      WAIT_WORD: begin
        if (cfg_valid && ready_q) begin
          shreg_d = cfg_data;
          last_d  = cfg_last;
          ready_d = 1'b0;
          bidx_d  = '0;
          head_d  = cfg_data[WORD_WIDTH-1];
          en_d    = (cnt_q < CHAIN_LEN_C);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d = shreg_q << 1;
        head_d  = shreg_q[WORD_WIDTH-2];
        cnt_d   = cnt_inc;
        if (en_q) begin
          // Counter still zero means this edge shifts the sequence's first bit.
          if (cnt_q == '0) first_bit_d = head_q;
        end else begin
          // A bit presented with the chain clock gated off is dropped.
          len_err_d = 1'b1;
        end
        if (bidx_q == LAST_BIT) begin
          en_d    = 1'b0;
          state_d = last_q ? CHECK : WAIT_WORD;
          ready_d = ~last_q;
        end else begin
          bidx_d = bidx_q + 1'b1;
          en_d   = (cnt_inc < CHAIN_LEN_C);
        end
      end
      CHECK: begin
        if (cnt_q != CHAIN_LEN_C)          len_err_d  = 1'b1;
        else if (ccff_tail != first_bit_q) tail_err_d = 1'b1;
        isol_d  = ~(len_err_d | tail_err_d);
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cfg_ready    = ready_q;
  assign ccff_head    = head_q;
  assign prog_clk_en  = en_q;
  assign isol_n       = isol_q;
  assign busy         = (state_q == WAIT_WORD) || (state_q == SHIFT) || (state_q == CHECK);
  assign done         = (state_q == DONE);
  assign tail_error   = tail_err_q;
  assign length_error = len_err_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Testbench for ccff_chain_loader with a behavioural 15/16-flop chain model.
module tb_ccff_chain_loader;

  logic       prog_clk = 1'b0;
  logic       prog_reset;
  logic       start;
  logic [7:0] cfg_data;
  logic       cfg_valid;
  logic       cfg_last;
  logic       cfg_ready;
  logic       ccff_head;
  logic       prog_clk_en;
  logic       ccff_tail;
  logic       isol_n;
  logic       busy;
  logic       done;
  logic       tail_error;
  logic       length_error;

  ccff_chain_loader #(.WORD_WIDTH(8), .CHAIN_LEN(16), .CNT_WIDTH(16)) dut (
    .prog_clk    (prog_clk),
    .prog_reset  (prog_reset),
    .start       (start),
    .cfg_data    (cfg_data),
    .cfg_valid   (cfg_valid),
    .cfg_last    (cfg_last),
    .cfg_ready   (cfg_ready),
    .ccff_head   (ccff_head),
    .prog_clk_en (prog_clk_en),
    .ccff_tail   (ccff_tail),
    .isol_n      (isol_n),
    .busy        (busy),
    .done        (done),
    .tail_error  (tail_error),
    .length_error(length_error)
  );

  always #5 prog_clk = ~prog_clk;

  // Chain model: chain[0] nearest head; tail is flop 15 (or 14 when short).
  logic [15:0] chain = '0;
  logic        chain_short = 1'b0;
  int          en_total = 0;

  always @(posedge prog_clk) begin
    if (prog_clk_en) begin
      chain    <= {chain[14:0], ccff_head};
      en_total <= en_total + 1;
    end
  end
  assign ccff_tail = chain_short ? chain[14] : chain[15];

  typedef struct {
    logic [15:0] chain;
    int          ens;
    logic        tail_e;
    logic        len_e;
    logic        isol;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   en_base  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic do_start();
    @(negedge prog_clk);
    start = 1'b1;
    @(negedge prog_clk);
    start   = 1'b0;
    en_base = en_total;
    chk("busy_after_start", busy, 1);
    chk("isol_after_start", isol_n, 0);
    chk("done_after_start", done, 0);
  endtask

  // Waits for cfg_ready, optionally idles 'gap' cycles checking the hold
  // behaviour, then hands over one word and checks the first head bit.
  task automatic send_word(input logic [7:0] d, input logic l, input int gap);
    int   k;
    logic h;
    k = 0;
    while (!cfg_ready && k < 50) begin
      @(negedge prog_clk);
      k++;
    end
    chk("ready_wait", cfg_ready, 1);
    h = ccff_head;
    for (int i = 0; i < gap; i++) begin
      @(negedge prog_clk);
      chk("gap_ready", cfg_ready, 1);
      chk("gap_en", prog_clk_en, 0);
      chk("gap_head", ccff_head, h);
    end
    cfg_data  = d;
    cfg_last  = l;
    cfg_valid = 1'b1;
    @(negedge prog_clk);
    cfg_valid = 1'b0;
    cfg_data  = 8'h00;
    chk("head_msb", ccff_head, d[7]);
    chk("ready_drop", cfg_ready, 0);
  endtask

  task automatic finish_seq();
    int   k;
    exp_t e;
    k = 0;
    while (!done && k < 300) begin
      @(negedge prog_clk);
      k++;
    end
    chk("done_seen", done, 1);
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("en_count", en_total - en_base, e.ens);
      chk("chain", chain, e.chain);
      chk("tail_error", tail_error, e.tail_e);
      chk("length_error", length_error, e.len_e);
      chk("isol_n", isol_n, e.isol);
      chk("busy_done", busy, 0);
    end
  endtask

  initial begin
    prog_reset = 1'b1;
    start      = 1'b0;
    cfg_data   = 8'h00;
    cfg_valid  = 1'b0;
    cfg_last   = 1'b0;
    repeat (2) @(negedge prog_clk);
    prog_reset = 1'b0;
    @(negedge prog_clk);
    chk("rst_ready", cfg_ready, 0);
    chk("rst_head", ccff_head, 0);
    chk("rst_en", prog_clk_en, 0);
    chk("rst_isol", isol_n, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_errs", {tail_error, length_error}, 0);

    // Clean two-word load into a 16-flop chain.
    sb.push_back('{16'hA53C, 16, 1'b0, 1'b0, 1'b1});
    do_start();
    send_word(8'hA5, 1'b0, 0);
    send_word(8'h3C, 1'b1, 0);
    finish_seq();

    // Chain one flop short: loopback mismatch.
    chain_short = 1'b1;
    sb.push_back('{16'hA53C, 16, 1'b1, 1'b0, 1'b0});
    do_start();
    send_word(8'hA5, 1'b0, 0);
    send_word(8'h3C, 1'b1, 0);
    finish_seq();
    chain_short = 1'b0;

    // Three words: third is entirely dropped.
    sb.push_back('{16'h0102, 16, 1'b0, 1'b1, 1'b0});
    do_start();
    send_word(8'h01, 1'b0, 0);
    send_word(8'h02, 1'b0, 0);
    send_word(8'h03, 1'b1, 0);
    finish_seq();

    // Single short word.
    sb.push_back('{16'h02FF, 8, 1'b0, 1'b1, 1'b0});
    do_start();
    send_word(8'hFF, 1'b1, 0);
    finish_seq();

    // Valid gap between words.
    sb.push_back('{16'hA53C, 16, 1'b0, 1'b0, 1'b1});
    do_start();
    send_word(8'hA5, 1'b0, 0);
    send_word(8'h3C, 1'b1, 5);
    finish_seq();

    // Reset in the 4th SHIFT cycle of word 1.
    do_start();
    send_word(8'hA5, 1'b0, 0);
    repeat (3) @(negedge prog_clk);
    prog_reset = 1'b1;
    #1;
    chk("mid_rst_en", prog_clk_en, 0);
    chk("mid_rst_head", ccff_head, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_isol", isol_n, 0);
    chk("mid_rst_ready", cfg_ready, 0);
    @(negedge prog_clk);
    prog_reset = 1'b0;
    sb.push_back('{16'hA53C, 16, 1'b0, 1'b0, 1'b1});
    do_start();
    send_word(8'hA5, 1'b0, 0);
    send_word(8'h3C, 1'b1, 0);
    finish_seq();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
